// File: rtl/restador_serial_5bits_pkg.sv
// Shared calculator definitions for the bit-serial subtractor: operand width, FSM encoding
// and the counter-width helper.
package restador_serial_5bits_pkg;

  localparam int unsigned OpWidth = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StFix   = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Bit counter width for an n-bit operand; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/restador_serial_5bits_resta_0.sv
// resta_0: combinational one-bit full subtractor (d = a - b - bin, bout = borrow out).
module resta_0 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/restador_serial_5bits.sv
// Bit-serial unsigned subtractor x = a - b, LSB first, with start/busy/done handshake.
// Define RESTA_MAGNITUD_EN for a sign-magnitude result (adds the FIX state, latency N+1).
module restador_serial_5bits
  import restador_serial_5bits_pkg::*;
#(
  parameter int unsigned N = OpWidth
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N:0]   x,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CntW = cnt_width(N);

  state_e            state_q, state_d;
  logic [N-1:0]      a_q, b_q, diff_q;
  logic              borrow_q;
  logic [CntW-1:0]   cnt_q;
  logic [N:0]        x_q;
  logic              d_bit, bout_bit, last_bit, accept;

  resta_0 u_resta (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign last_bit = (cnt_q == CntW'(N - 1));
  assign accept   = start && ((state_q == StIdle) || (state_q == StDone));

`ifdef RESTA_MAGNITUD_EN
  logic [N-1:0] diff_neg;
  assign diff_neg = ~diff_q + {{(N-1){1'b0}}, 1'b1};
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: begin
        if (last_bit) begin
`ifdef RESTA_MAGNITUD_EN
          state_d = StFix;
`else
          state_d = StDone;
`endif
        end
      end
      StFix:   state_d = StDone;
      StDone:  state_d = start ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StShift) || (state_q == StFix);
    done = (state_q == StDone);
    x    = x_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      x_q      <= '0;
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (state_q == StShift) begin
      a_q      <= a_q >> 1;
      b_q      <= b_q >> 1;
      borrow_q <= bout_bit;
      cnt_q    <= cnt_q + CntW'(1);
      // Difference bits enter at the MSB so the LSB lands at bit 0 after N shifts.
      diff_q   <= {d_bit, diff_q[N-1:1]};
`ifndef RESTA_MAGNITUD_EN
      if (last_bit) x_q <= {bout_bit, d_bit, diff_q[N-1:1]};
`endif
    end
`ifdef RESTA_MAGNITUD_EN
    else if (state_q == StFix) begin
      x_q <= borrow_q ? {1'b1, diff_neg} : {1'b0, diff_q};
    end
`endif
  end

endmodule

// File: tb/tb_restador_serial_5bits.sv
// Scoreboard bench for restador_serial_5bits: directed spec cases plus random operations.
`timescale 1ns/1ps
module tb_restador_serial_5bits;

  localparam int unsigned N = 5;
`ifdef RESTA_MAGNITUD_EN
  localparam int unsigned Lat = N + 1;
`else
  localparam int unsigned Lat = N;
`endif

  logic         clk = 1'b0;
  logic         rst, start;
  logic [N-1:0] a, b;
  logic [N:0]   x;
  logic         busy, done;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  logic [N:0]  exp_q[$];
  int unsigned acc_q[$];

  restador_serial_5bits #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .x     (x),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: signed difference, then formatted as the spec's result encoding.
  function automatic logic [N:0] model(input int unsigned av, input int unsigned bv);
    int diff;
    int mag;
    diff = int'(av) - int'(bv);
`ifdef RESTA_MAGNITUD_EN
    mag = (diff < 0) ? -diff : diff;
    return {(diff < 0) ? 1'b1 : 1'b0, mag[N-1:0]};
`else
    return diff[N:0];
`endif
  endfunction

  // Monitor: samples 2ns after each rising edge, away from the driver's falling-edge updates.
  logic [N:0] x_prev;
  int         busy_cnt = 0;
  always begin
    logic [N:0]  e;
    int unsigned t;
    @(posedge clk);
    #2;
    if (rst === 1'b1) begin
      check("done_in_reset", {31'd0, done}, 32'd0);
      busy_cnt = 0;
    end else begin
      if (busy === 1'b1) check("x_hold_while_busy", {26'd0, x}, {26'd0, x_prev});
      if (done === 1'b1) begin
        check("busy_low_on_done", {31'd0, busy}, 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 x=%b, required no pulse", x);
        end else begin
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          check("result_x", {26'd0, x}, {26'd0, e});
          check("latency", cyc - t - 1, Lat);
          check("busy_cycles", busy_cnt, Lat);
        end
        busy_cnt = 0;
      end else if (busy === 1'b1) begin
        busy_cnt++;
      end
    end
    x_prev = x;
  end

  // Called at a falling edge; waits for IDLE/DONE, presents start for one cycle.
  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic [N:0] e, input bit push);
    int k = 0;
    while (busy !== 1'b0) begin
      @(negedge clk);
      k++;
      if (k > 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wait_idle_timeout: got busy=%b, required 0 within 100 cycles", busy);
        return;
      end
    end
    start = 1'b1;
    a     = av;
    b     = bv;
    if (push) begin
      exp_q.push_back(e);
      acc_q.push_back(cyc);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_done_timeout: got done=%b, required 1 within 100 cycles", done);
    end
  endtask

  initial begin
    int k;
    rst   = 1'b1;
    start = 1'b1;
    a     = 5'd20;
    b     = 5'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_x", {26'd0, x}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_after_reset_busy", {31'd0, busy}, 32'd0);

    // 20 - 7 = 13 in both formats; a stray start mid-SHIFT must be ignored.
    issue(5'd20, 5'd7, 6'b001101, 1'b1);
    @(negedge clk);
    start = 1'b1;
    a     = 5'd1;
    b     = 5'd1;
    @(negedge clk);
    start = 1'b0;

`ifdef RESTA_MAGNITUD_EN
    issue(5'd3, 5'd5, 6'b100010, 1'b1);
`else
    issue(5'd3, 5'd5, 6'b111110, 1'b1);
`endif

    // Reset during bit 2 of 31 - 1 aborts with no done pulse and clears x.
    issue(5'd31, 5'd1, '0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_x", {26'd0, x}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(5'd31, 5'd1, 6'b011110, 1'b1);

`ifdef RESTA_MAGNITUD_EN
    issue(5'd0, 5'd31, 6'b111111, 1'b1);
`else
    issue(5'd0, 5'd31, 6'b100001, 1'b1);
`endif
    // Back-to-back: start on the done cycle, next operation begins with no idle gap.
    wait_done();
    issue(5'd9, 5'd9, 6'b000000, 1'b1);
    check("b2b_no_gap_busy", {31'd0, busy}, 32'd1);

    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] ra, rb;
      ra = N'($urandom_range(0, 31));
      rb = N'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) wait_done();
      else repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(ra, rb, model(ra, rb), 1'b1);
    end

    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
